// File: rtl/mapper_irq_unit_if.sv
// Register-write, ppu_a12 sample and irq/counter readback bundle between a mapper and mapper_irq_unit.
interface mapper_irq_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 reg_we;
  logic [2:0]           reg_sel;
  logic [7:0]           reg_data;
  logic                 ppu_a12;
  logic                 irq;
  logic [CNT_WIDTH-1:0] counter;

  modport master (
    output reg_we, reg_sel, reg_data, ppu_a12,
    input  irq, counter
  );

  modport slave (
    input  reg_we, reg_sel, reg_data, ppu_a12,
    output irq, counter
  );
endinterface

// File: rtl/mapper_irq_unit.sv
// Shared mapper IRQ counter (A12 scanline / CPU cycle / VRC prescaled); irq is registered one m2 after its event, writes never stall.
// `MAPPER_IRQ_A12_FILTER_EN adds a minimum ppu_a12 low-run filter before a rise counts as a scanline event.
module mapper_irq_unit #(
  parameter int CNT_WIDTH  = 16,
  parameter int A12_FILTER = 3,
  parameter int PRESCALE   = 341
) (
  input  logic              m2,
  input  logic              reset,
  mapper_irq_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_A12  = 2'b00,
    MODE_CPU  = 2'b01,
    MODE_VRC  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [9:0]    PRE_INIT = 10'(PRESCALE);

  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] latch_q, latch_d;
  logic [4:0]           ctrl_q, ctrl_d;
  logic                 reload_flag_q, reload_flag_d;
  logic                 irq_q, irq_d;
  logic signed [9:0]    prescaler_q, prescaler_d;
  logic                 a12_prev_q;

  logic                 a12_event;
  logic                 cnt_wr;
  logic                 count_upd;
  logic                 irq_set;
  logic [CNT_WIDTH-1:0] count_val;
  logic signed [9:0]    presc_sub;
  logic [15:0]          latch16;
  logic [15:0]          cnt16;
  mode_e                mode;

  assign mode = mode_e'(ctrl_q[2:1]);

`ifdef MAPPER_IRQ_A12_FILTER_EN
  localparam int              LW     = (A12_FILTER < 1) ? 1 : $clog2(A12_FILTER + 1);
  localparam logic [LW-1:0]   LC_MAX = LW'(A12_FILTER);
  localparam logic [LW-1:0]   LC_ONE = LW'(1);
  logic [LW-1:0] low_cnt_q, low_cnt_d;

  // Length of the current low run, saturating once it is long enough to qualify a rise.
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (bus.ppu_a12) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LC_MAX) begin
      low_cnt_d = low_cnt_q + LC_ONE;
    end
  end

  always_ff @(posedge m2) begin
    if (reset) low_cnt_q <= '0;
    else       low_cnt_q <= low_cnt_d;
  end

  assign a12_event = bus.ppu_a12 && !a12_prev_q && (low_cnt_q >= LC_MAX);
`else
  assign a12_event = bus.ppu_a12 && !a12_prev_q;
`endif

  always_comb begin
    counter_d     = counter_q;
    latch_d       = latch_q;
    ctrl_d        = ctrl_q;
    reload_flag_d = reload_flag_q;
    irq_d         = irq_q;
    prescaler_d   = prescaler_q;
    count_upd     = 1'b0;
    irq_set       = 1'b0;
    count_val     = counter_q;
    presc_sub     = prescaler_q - 10'sd3;
    latch16       = 16'(latch_q);
    cnt16         = 16'(counter_q);
    cnt_wr        = bus.reg_we && (bus.reg_sel inside {3'd4, 3'd5, 3'd6});

    case (mode)
      MODE_A12: begin
        if (a12_event) begin
          count_upd = 1'b1;
          count_val = (counter_q == CNT_ZERO || reload_flag_q) ? latch_q : counter_q - CNT_ONE;
          irq_set   = (count_val == CNT_ZERO) && ctrl_q[0];
        end
      end
      MODE_CPU: begin
        if (ctrl_q[0]) begin
          count_upd = 1'b1;
          if (ctrl_q[4]) begin
            irq_set   = (counter_q == CNT_MAX);
            count_val = counter_q + CNT_ONE;
          end else begin
            irq_set   = (counter_q == CNT_ZERO);
            count_val = counter_q - CNT_ONE;
          end
          if (irq_set && ctrl_q[3]) count_val = latch_q;
        end
      end
      MODE_VRC: begin
        if (ctrl_q[0]) begin
          prescaler_d = presc_sub;
          if (presc_sub <= 10'sd0) begin
            prescaler_d = presc_sub + PRE_INIT;
            count_upd   = 1'b1;
            irq_set     = (counter_q == CNT_MAX);
            count_val   = irq_set ? latch_q : counter_q + CNT_ONE;
          end
        end
      end
      default: ;
    endcase

    // A same-cycle counter write discards the whole count, irq included.
    if (count_upd && !cnt_wr) begin
      counter_d = count_val;
      if (mode == MODE_A12) reload_flag_d = 1'b0;
    end

    if (bus.reg_we) begin
      case (bus.reg_sel)
        3'd0: begin
          latch16[7:0] = bus.reg_data;
          latch_d      = latch16[CNT_WIDTH-1:0];
        end
        3'd1: begin
          latch16[15:8] = bus.reg_data;
          latch_d       = latch16[CNT_WIDTH-1:0];
        end
        3'd2: begin
          ctrl_d      = bus.reg_data[4:0];
          prescaler_d = PRE_INIT;
          if (!bus.reg_data[0]) irq_d = 1'b0;
        end
        3'd3: begin
          irq_d = 1'b0;
          if (mode == MODE_VRC) ctrl_d[0] = ctrl_q[3];
        end
        3'd4: begin
          cnt16[7:0] = bus.reg_data;
          counter_d  = cnt16[CNT_WIDTH-1:0];
        end
        3'd5: begin
          cnt16[15:8] = bus.reg_data;
          counter_d   = cnt16[CNT_WIDTH-1:0];
        end
        3'd6: begin
          reload_flag_d = 1'b1;
          counter_d     = CNT_ZERO;
        end
        default: ;
      endcase
    end

    if (irq_set && !cnt_wr) irq_d = 1'b1;
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      counter_q     <= CNT_ZERO;
      latch_q       <= CNT_ZERO;
      ctrl_q        <= 5'd0;
      reload_flag_q <= 1'b0;
      irq_q         <= 1'b0;
      prescaler_q   <= PRE_INIT;
      a12_prev_q    <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      latch_q       <= latch_d;
      ctrl_q        <= ctrl_d;
      reload_flag_q <= reload_flag_d;
      irq_q         <= irq_d;
      prescaler_q   <= prescaler_d;
      a12_prev_q    <= bus.ppu_a12;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.counter = counter_q;

endmodule

// File: tb/tb_mapper_irq_unit.sv
// Directed bench for mapper_irq_unit at CNT_WIDTH=8; expectations follow the A12 filter macro when it is defined.
module tb_mapper_irq_unit;

  logic m2;
  logic reset;
  int   checks;
  int   errors;

  mapper_irq_unit_if #(.CNT_WIDTH(8)) bus ();

  mapper_irq_unit #(.CNT_WIDTH(8), .A12_FILTER(3), .PRESCALE(341)) dut (
    .m2    (m2),
    .reset (reset),
    .bus   (bus)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge m2);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    bus.reg_we   = 1'b1;
    bus.reg_sel  = sel;
    bus.reg_data = data;
    cyc();
    bus.reg_we   = 1'b0;
  endtask

  // Low for 'low' samples, then high; the event edge is the first high sample.
  task automatic a12_pulse(input int low, input int high);
    bus.ppu_a12 = 1'b0;
    cyc(low);
    bus.ppu_a12 = 1'b1;
    cyc(high);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
    checks++;
    if (bus.counter !== 8'h00) begin
      errors++; $display("FAIL reset_counter: got %h want 00", bus.counter);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_a12_scanline;
    logic [7:0] exp_cnt [8] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
    wr(3'd0, 8'd3);
    wr(3'd6, 8'd0);
    wr(3'd2, 8'h01);
    checks++;
    if (bus.counter !== 8'h00) begin
      errors++; $display("FAIL a12_reload_req: got %h want 00", bus.counter);
    end
    for (int i = 0; i < 8; i++) begin
      a12_pulse(4, 2);
      checks++;
      if (bus.counter !== exp_cnt[i]) begin
        errors++; $display("FAIL a12_cnt rise %0d: got %0d want %0d", i + 1, bus.counter, exp_cnt[i]);
      end
      checks++;
      if (bus.irq !== ((i == 3) || (i == 7))) begin
        errors++; $display("FAIL a12_irq rise %0d: got %b want %b", i + 1, bus.irq, (i == 3) || (i == 7));
      end
      if (i == 3 || i == 7) begin
        wr(3'd3, 8'd0);
        checks++;
        if (bus.irq !== 1'b0) begin
          errors++; $display("FAIL a12_ack rise %0d: got %b want 0", i + 1, bus.irq);
        end
      end
    end
  endtask

  task automatic test_a12_filter;
    logic [7:0] e_short, e_long;
`ifdef MAPPER_IRQ_A12_FILTER_EN
    e_short = 8'd3;
    e_long  = 8'd2;
`else
    e_short = 8'd2;
    e_long  = 8'd1;
`endif
    a12_pulse(5, 2);
    checks++;
    if (bus.counter !== 8'd3) begin
      errors++; $display("FAIL filt_reload: got %0d want 3", bus.counter);
    end
    a12_pulse(2, 2);
    checks++;
    if (bus.counter !== e_short) begin
      errors++; $display("FAIL filt_low2: got %0d want %0d", bus.counter, e_short);
    end
    a12_pulse(3, 2);
    checks++;
    if (bus.counter !== e_long) begin
      errors++; $display("FAIL filt_low3: got %0d want %0d", bus.counter, e_long);
    end
    bus.ppu_a12 = 1'b0;
  endtask

  task automatic test_cpu_cycle;
    wr(3'd2, 8'h00);
    wr(3'd0, 8'h10);
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h02);
    wr(3'd5, 8'hAB);
    checks++;
    if (bus.counter !== 8'h02) begin
      errors++; $display("FAIL cpu_hi_byte_ignored: got %h want 02", bus.counter);
    end
    wr(3'd2, 8'h0B);
    checks++;
    if (bus.counter !== 8'h02) begin
      errors++; $display("FAIL cpu_enable_edge: got %h want 02", bus.counter);
    end
    cyc();
    cyc();
    checks++;
    if (bus.counter !== 8'h00 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL cpu_cycle2: got %h/%b want 00/0", bus.counter, bus.irq);
    end
    cyc();
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++; $display("FAIL cpu_wrap_irq: got %b want 1", bus.irq);
    end
    checks++;
    if (bus.counter !== 8'h10) begin
      errors++; $display("FAIL cpu_autoreload: got %h want 10", bus.counter);
    end
    cyc();
    checks++;
    if (bus.counter !== 8'h0F || bus.irq !== 1'b1) begin
      errors++; $display("FAIL cpu_irq_held: got %h/%b want 0f/1", bus.counter, bus.irq);
    end
    wr(3'd3, 8'd0);
    checks++;
    if (bus.counter !== 8'h0E || bus.irq !== 1'b0) begin
      errors++; $display("FAIL cpu_ack: got %h/%b want 0e/0", bus.counter, bus.irq);
    end
  endtask

  task automatic test_same_cycle;
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h01);
    wr(3'd2, 8'h0B);
    cyc();
    wr(3'd3, 8'd0);
    checks++;
    if (bus.irq !== 1'b1 || bus.counter !== 8'h10) begin
      errors++; $display("FAIL ack_vs_wrap: got %b/%h want 1/10", bus.irq, bus.counter);
    end
    wr(3'd4, 8'h55);
    checks++;
    if (bus.counter !== 8'h55) begin
      errors++; $display("FAIL write_vs_count: got %h want 55", bus.counter);
    end
    cyc();
    checks++;
    if (bus.counter !== 8'h54) begin
      errors++; $display("FAIL count_after_write: got %h want 54", bus.counter);
    end
    wr(3'd2, 8'h00);
    checks++;
    if (bus.irq !== 1'b0 || bus.counter !== 8'h53) begin
      errors++; $display("FAIL disable_clears_irq: got %b/%h want 0/53", bus.irq, bus.counter);
    end
    wr(3'd4, 8'hFE);
    wr(3'd2, 8'h13);
    cyc();
    checks++;
    if (bus.counter !== 8'hFF || bus.irq !== 1'b0) begin
      errors++; $display("FAIL up_to_max: got %h/%b want ff/0", bus.counter, bus.irq);
    end
    cyc();
    checks++;
    if (bus.counter !== 8'h00 || bus.irq !== 1'b1) begin
      errors++; $display("FAIL up_wrap: got %h/%b want 00/1", bus.counter, bus.irq);
    end
    wr(3'd2, 8'h00);
    checks++;
    if (bus.counter !== 8'h01 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL up_disable: got %h/%b want 01/0", bus.counter, bus.irq);
    end
  endtask

  task automatic test_vrc;
    int         n;
    logic [7:0] prev;
    wr(3'd0, 8'hFE);
    wr(3'd4, 8'hFE);
    wr(3'd2, 8'h05);
    for (int t = 0; t < 2; t++) begin
      n    = 0;
      prev = bus.counter;
      while (n < 300 && bus.counter === prev) begin
        cyc();
        n++;
      end
      checks++;
      if (n !== 114) begin
        errors++; $display("FAIL vrc_tick%0d_period: got %0d cycles want 114", t + 1, n);
      end
      checks++;
      if (bus.counter !== ((t == 0) ? 8'hFF : 8'hFE) || bus.irq !== (t == 1)) begin
        errors++; $display("FAIL vrc_tick%0d: got %h/%b want %h/%b", t + 1, bus.counter, bus.irq,
                           (t == 0) ? 8'hFF : 8'hFE, t == 1);
      end
    end
    wr(3'd3, 8'd0);
    cyc(150);
    checks++;
    if (bus.counter !== 8'hFE || bus.irq !== 1'b0) begin
      errors++; $display("FAIL vrc_ack_disables: got %h/%b want fe/0", bus.counter, bus.irq);
    end
    wr(3'd2, 8'h07);
    cyc(5);
    checks++;
    if (bus.counter !== 8'hFE) begin
      errors++; $display("FAIL mode11_hold: got %h want fe", bus.counter);
    end
  endtask

  task automatic test_reset_mid;
    wr(3'd4, 8'h00);
    wr(3'd2, 8'h03);
    cyc();
    checks++;
    if (bus.irq !== 1'b1 || bus.counter !== 8'hFF) begin
      errors++; $display("FAIL pre_reset_wrap: got %b/%h want 1/ff", bus.irq, bus.counter);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (bus.irq !== 1'b0 || bus.counter !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got %b/%h want 0/00", bus.irq, bus.counter);
    end
    checks++;
    if (dut.prescaler_q !== 10'sd341) begin
      errors++; $display("FAIL mid_reset_prescaler: got %0d want 341", dut.prescaler_q);
    end
    reset = 1'b0;
    cyc(3);
    checks++;
    if (bus.irq !== 1'b0 || bus.counter !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle: got %b/%h want 0/00", bus.irq, bus.counter);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.reg_we   = 1'b0;
    bus.reg_sel  = 3'd0;
    bus.reg_data = 8'd0;
    bus.ppu_a12  = 1'b0;
    test_reset();
    test_a12_scanline();
    test_a12_filter();
    test_cpu_cycle();
    test_same_cycle();
    test_vrc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
